// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects and the scoreboard entry format.
package pipeline_ctrl_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  localparam logic [1:0] FwdRegfile = 2'b00;
  localparam logic [1:0] FwdExMem   = 2'b01;
  localparam logic [1:0] FwdMemWb   = 2'b10;
  localparam logic [1:0] FwdRetired = 2'b11;

  // Widest register address an entry can hold; narrower addresses are zero-extended.
  localparam int unsigned SbRdW = 8;

  typedef struct packed {
    logic             v;
    logic [SbRdW-1:0] rd;
    logic             ld;
  } sb_entry_t;

  // Entry written for a bubble or a flushed instruction.
  localparam sb_entry_t SbNop = '{v: 1'b0, rd: '0, ld: 1'b0};

  // hits[0] is the youngest in-flight producer (EX), hits[2] the oldest (WB).
  function automatic logic [1:0] youngest_sel(logic [2:0] hits);
    logic [1:0] sel;
    sel = FwdRegfile;
    if (hits[2]) sel = FwdRetired;
    if (hits[1]) sel = FwdMemWb;
    if (hits[0]) sel = FwdExMem;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry scoreboard of in-flight destinations (EX, MEM, WB) with RAW match,
// stall decision and registered forwarding selects for the instruction leaving ID.
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned RA_W   = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            advance,
  input  logic            load_nop,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  output logic            stall,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel
);

  sb_entry_t        sb_q [3];
  sb_entry_t        issue;
  logic [2:0]       hit_a, hit_b;
  logic [SbRdW-1:0] rs1_x, rs2_x;

  assign rs1_x = SbRdW'(id_rs1);
  assign rs2_x = SbRdW'(id_rs2);

  always_comb begin
    issue    = SbNop;
    issue.v  = id_valid & id_reg_write & (id_rd != '0);
    issue.rd = SbRdW'(id_rd);
    issue.ld = id_is_load;
  end

  // x0 is hardwired, so a read of x0 never depends on anything in flight.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 0; k < 3; k++) begin
      hit_a[k] = id_valid & id_use_rs1 & (id_rs1 != '0) & sb_q[k].v & (sb_q[k].rd == rs1_x);
      hit_b[k] = id_valid & id_use_rs2 & (id_rs2 != '0) & sb_q[k].v & (sb_q[k].rd == rs2_x);
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sb_q[0] <= SbNop;
      sb_q[1] <= SbNop;
      sb_q[2] <= SbNop;
    end else if (advance) begin
      sb_q[2] <= sb_q[1];
      sb_q[1] <= sb_q[0];
      sb_q[0] <= load_nop ? SbNop : issue;
    end
  end

  if (FWD_EN) begin : g_fwd
    logic [1:0] fwd_a_q, fwd_b_q;

    // Only a load still in EX cannot be bypassed.
    assign stall = (hit_a[0] | hit_b[0]) & sb_q[0].ld;

    always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
        fwd_a_q <= FwdRegfile;
        fwd_b_q <= FwdRegfile;
      end else if (advance) begin
        fwd_a_q <= load_nop ? FwdRegfile : youngest_sel(hit_a);
        fwd_b_q <= load_nop ? FwdRegfile : youngest_sel(hit_b);
      end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
  end else begin : g_nofwd
    assign stall     = |{hit_a, hit_b};
    assign fwd_a_sel = FwdRegfile;
    assign fwd_b_sel = FwdRegfile;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: run/freeze FSM, redirect flush, load-use bubbles,
// forwarding selects and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned RA_W   = 5,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             RUN_EN,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_RegWrite,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             CNTEN,
  output logic             PCsel,
  output logic             IFID_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_EN,
  output logic             IDEX_BUBBLE,
  output logic             EXMEM_EN,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             running, frozen, advance, stall;

  assign running = (state_q != StIdle);
  // The ack cycle of an outstanding access already advances.
  assign frozen  = ((state_q == StRun) & mem_req & ~mem_ack) |
                   ((state_q == StMemWait) & ~mem_ack);
  assign advance = running & ~frozen;

  hazard_scoreboard #(
    .RA_W   (RA_W),
    .FWD_EN (FWD_EN)
  ) u_scoreboard (
    .CLK          (CLK),
    .RSTB         (RSTB),
    .advance      (advance),
    .load_nop     (ex_redirect | stall),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_RegWrite),
    .id_is_load   (id_is_load),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel)
  );

  // Bubble and flush are written through the normal load enables of their registers.
  always_comb begin
    CNTEN       = 1'b0;
    PCsel       = 1'b0;
    IFID_EN     = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_EN     = 1'b0;
    IDEX_BUBBLE = 1'b0;
    EXMEM_EN    = 1'b0;
    if (advance) begin
      IDEX_EN  = 1'b1;
      EXMEM_EN = 1'b1;
      if (ex_redirect) begin
        CNTEN       = 1'b1;
        PCsel       = 1'b1;
        IFID_EN     = 1'b1;
        IFID_FLUSH  = 1'b1;
        IDEX_BUBBLE = 1'b1;
      end else if (stall) begin
        IDEX_BUBBLE = 1'b1;
      end else begin
        CNTEN   = 1'b1;
        IFID_EN = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (RUN_EN) state_d = StRun;
      StRun:     if (mem_req & ~mem_ack) state_d = StMemWait;
      StMemWait: if (mem_ack) state_d = StRun;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= StIdle;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (running && !CNTEN && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a forwarding instance and a no-forwarding instance
// with a narrow stall counter, both checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RSTB = 1'b0;
  logic       RUN_EN = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_use_rs1 = 1'b0;
  logic       id_use_rs2 = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_RegWrite = 1'b0;
  logic       id_is_load = 1'b0;
  logic       ex_redirect = 1'b0;
  logic       mem_req = 1'b0;
  logic       mem_ack = 1'b0;

  // Index 1: FWD_EN=1, CNT_W=16. Index 0: FWD_EN=0, CNT_W=4.
  logic [1:0]  cnten, pcsel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
  logic [1:0]  fwd_a [2];
  logic [1:0]  fwd_b [2];
  logic [15:0] scnt1;
  logic [3:0]  scnt0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.RA_W(5), .FWD_EN(1'b1), .CNT_W(16)) dut1 (
    .CLK(CLK), .RSTB(RSTB), .RUN_EN(RUN_EN), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .CNTEN(cnten[1]), .PCsel(pcsel[1]),
    .IFID_EN(ifid_en[1]), .IFID_FLUSH(ifid_flush[1]), .IDEX_EN(idex_en[1]),
    .IDEX_BUBBLE(idex_bubble[1]), .EXMEM_EN(exmem_en[1]), .fwd_a_sel(fwd_a[1]),
    .fwd_b_sel(fwd_b[1]), .stall_cnt(scnt1)
  );

  pipeline_hazard_ctrl #(.RA_W(5), .FWD_EN(1'b0), .CNT_W(4)) dut0 (
    .CLK(CLK), .RSTB(RSTB), .RUN_EN(RUN_EN), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_RegWrite(id_RegWrite), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ack(mem_ack), .CNTEN(cnten[0]), .PCsel(pcsel[0]),
    .IFID_EN(ifid_en[0]), .IFID_FLUSH(ifid_flush[0]), .IDEX_EN(idex_en[0]),
    .IDEX_BUBBLE(idex_bubble[0]), .EXMEM_EN(exmem_en[0]), .fwd_a_sel(fwd_a[0]),
    .fwd_b_sel(fwd_b[0]), .stall_cnt(scnt0)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per instance, a machine phase (0 idle, 1 running, 2 waiting on memory) and
  // the producers in flight, age 0 = just issued into EX.
  int         m_st  [2];
  bit         m_v   [2][3];
  logic [4:0] m_rd  [2][3];
  bit         m_ld  [2][3];
  int         m_fa  [2];
  int         m_fb  [2];
  int         m_cnt [2];

  function automatic int youngest(int c, logic [4:0] rs, bit used);
    for (int k = 0; k < 3; k++)
      if (used && rs != 0 && m_v[c][k] && m_rd[c][k] == rs) return k;
    return -1;
  endfunction

  task automatic model_step(int c);
    logic [6:0] exp_ctrl, act_ctrl;
    int         ya, yb, cmax, act_cnt;
    bit         running, frozen, adv, stall, nop;
    string      tag;
    tag  = (c == 1) ? "fwd1" : "fwd0";
    cmax = (c == 1) ? 65535 : 15;
    if (!RSTB) begin
      m_st[c] = 0;
      for (int k = 0; k < 3; k++) m_v[c][k] = 0;
      m_fa[c] = 0;
      m_fb[c] = 0;
      m_cnt[c] = 0;
    end
    running = (m_st[c] != 0);
    frozen  = (m_st[c] == 1 && mem_req && !mem_ack) || (m_st[c] == 2 && !mem_ack);
    adv     = running && !frozen;
    ya = youngest(c, id_rs1, id_valid && id_use_rs1);
    yb = youngest(c, id_rs2, id_valid && id_use_rs2);
    if (c == 1) stall = (ya == 0 || yb == 0) && m_ld[c][0];
    else        stall = (ya >= 0) || (yb >= 0);
    // {CNTEN, PCsel, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_BUBBLE, EXMEM_EN}
    if (!adv)             exp_ctrl = 7'b0000000;
    else if (ex_redirect) exp_ctrl = 7'b1111111;
    else if (stall)       exp_ctrl = 7'b0000111;
    else                  exp_ctrl = 7'b1010101;
    act_ctrl = {cnten[c], pcsel[c], ifid_en[c], ifid_flush[c], idex_en[c], idex_bubble[c],
                exmem_en[c]};
    act_cnt = (c == 1) ? int'(scnt1) : int'(scnt0);
    chk({tag, "_ctrl"}, int'(act_ctrl), int'(exp_ctrl));
    chk({tag, "_fwd_a"}, int'(fwd_a[c]), m_fa[c]);
    chk({tag, "_fwd_b"}, int'(fwd_b[c]), m_fb[c]);
    chk({tag, "_stall_cnt"}, act_cnt, m_cnt[c]);
    if (RSTB) begin
      if (running && !exp_ctrl[6]) m_cnt[c] = (m_cnt[c] == cmax) ? cmax : m_cnt[c] + 1;
      if (adv) begin
        nop = ex_redirect || stall;
        m_fa[c] = (nop || c == 0) ? 0 : ya + 1;
        m_fb[c] = (nop || c == 0) ? 0 : yb + 1;
        for (int k = 2; k > 0; k--) begin
          m_v[c][k]  = m_v[c][k-1];
          m_rd[c][k] = m_rd[c][k-1];
          m_ld[c][k] = m_ld[c][k-1];
        end
        m_v[c][0]  = !nop && id_valid && id_RegWrite && id_rd != 0;
        m_rd[c][0] = id_rd;
        m_ld[c][0] = id_is_load;
      end
      case (m_st[c])
        0:       if (RUN_EN) m_st[c] = 1;
        1:       if (mem_req && !mem_ack) m_st[c] = 2;
        default: if (mem_ack) m_st[c] = 1;
      endcase
    end
  endtask

  always @(negedge CLK) begin
    model_step(1);
    model_step(0);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_RegWrite = rw; id_is_load = ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  int saved;

  initial begin
    repeat (5) cyc();
    #1;
    chk("rst_cnten", int'(cnten[1]), 0);
    chk("rst_enables", int'({ifid_en[1], idex_en[1], exmem_en[1]}), 0);
    chk("rst_stall_cnt", int'(scnt1), 0);
    chk("rst_fwd", int'({fwd_a[1], fwd_b[1]}), 0);
    cyc(); RSTB = 1'b1;
    cyc();
    cyc();
    cyc(); RUN_EN = 1'b1; #1 chk("idle_cnten", int'(cnten[1]), 0);
    cyc(); #1 chk("run_cnten", int'(cnten[1]), 1);

    // lw x5; add x6,x5,x1
    idle(3);
    cyc(); set_id(1, 2, 1, 0, 0, 5, 1, 1);
    cyc(); set_id(1, 5, 1, 1, 1, 6, 1, 0);
    #1 chk("lu_bubble", int'(idex_bubble[1]), 1);
    chk("lu_cnten", int'(cnten[1]), 0);
    cyc(); #1 chk("lu_issue_cnten", int'(cnten[1]), 1);
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("lu_fwd_a", int'(fwd_a[1]), 2);
    chk("lu_fwd_b", int'(fwd_b[1]), 0);

    // addi x5; addi x5; sub x7,x5,x5
    idle(3);
    saved = m_cnt[1];
    cyc(); set_id(1, 0, 1, 0, 0, 5, 1, 0);
    cyc(); set_id(1, 0, 1, 0, 0, 5, 1, 0);
    cyc(); set_id(1, 5, 1, 5, 1, 7, 1, 0);
    #1 chk("yng_cnten", int'(cnten[1]), 1);
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("yng_fwd", int'({fwd_a[1], fwd_b[1]}), 4'b0101);
    chk("yng_cnt_same", int'(scnt1), saved);

    // producer of x0 then consumer of x0
    idle(3);
    cyc(); set_id(1, 1, 1, 0, 0, 0, 1, 1);
    cyc(); set_id(1, 0, 1, 0, 1, 8, 1, 0);
    #1 chk("x0_cnten", int'({cnten[1], cnten[0]}), 2'b11);
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("x0_fwd", int'({fwd_a[1], fwd_b[1]}), 0);

    // taken branch over a pending load-use stall
    idle(3);
    cyc(); set_id(1, 2, 1, 0, 0, 5, 1, 1);
    cyc(); set_id(1, 5, 1, 1, 1, 6, 1, 0); ex_redirect = 1'b1;
    #1 chk("br_ctrl", int'({cnten[1], pcsel[1], ifid_flush[1], idex_bubble[1]}), 4'b1111);
    cyc(); ex_redirect = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("br_fwd", int'(fwd_a[1]), 0);

    // memory busy 3 cycles with a redirect held in EX
    idle(3);
    saved = m_cnt[1];
    cyc(); mem_req = 1'b1; ex_redirect = 1'b1;
    #1 chk("mw_freeze", int'({cnten[1], pcsel[1], exmem_en[1]}), 0);
    cyc(); #1 chk("mw_wait_pcsel", int'(pcsel[1]), 0);
    cyc();
    cyc(); mem_ack = 1'b1;
    #1 chk("mw_ack_pcsel", int'({cnten[1], pcsel[1]}), 2'b11);
    cyc(); mem_ack = 1'b0; mem_req = 1'b0; ex_redirect = 1'b0;
    #1 chk("mw_after_pcsel", int'(pcsel[1]), 0);
    chk("mw_stall_cnt", int'(scnt1), saved + 3);

    // no forwarding: addi x5; add x6,x5,x0
    idle(3);
    cyc(); set_id(1, 0, 1, 0, 0, 5, 1, 0);
    cyc(); set_id(1, 5, 1, 0, 1, 6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("nf_stall", int'(cnten[0]), 0);
      cyc();
    end
    #1 chk("nf_issue", int'(cnten[0]), 1);
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("nf_fwd", int'({fwd_a[0], fwd_b[0]}), 0);

    // reset while waiting on memory
    cyc(); set_id(1, 0, 0, 0, 0, 9, 1, 1);
    cyc(); set_id(0, 0, 0, 0, 0, 0, 0, 0); mem_req = 1'b1;
    cyc(); #2 RSTB = 1'b0;
    #1 chk("mr_ctrl", int'({cnten, exmem_en, idex_en}), 0);
    chk("mr_cnt", int'(scnt1) + int'(scnt0), 0);
    chk("mr_fwd", int'({fwd_a[1], fwd_b[1]}), 0);
    cyc(); RSTB = 1'b1; mem_req = 1'b0;
    cyc(); set_id(1, 9, 1, 0, 0, 10, 1, 0);
    #1 chk("mr_sb_empty", int'({cnten[1], cnten[0]}), 2'b11);

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 4000; i++) begin
      cyc();
      RSTB        = ($urandom_range(0, 599) != 0);
      RUN_EN      = ($urandom_range(0, 9) != 0);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      id_rd       = 5'($urandom_range(0, 3));
      id_RegWrite = ($urandom_range(0, 3) != 0);
      id_is_load  = ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_req     = ($urandom_range(0, 4) == 0);
      mem_ack     = 1'($urandom_range(0, 1));
    end
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
